// File: rtl/fetch_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : fetch_pkg
// Purpose  : Shared types, constants and helpers for the fetch PC generator
//            and its branch target buffer.
// Contents : btb_entry_t   - one BTB line (valid, tag, target, 2-bit counter)
//            CTR_WEAK_NT   - counter value after reset/flush
//            CTR_WEAK_T    - counter value on fresh allocation
//            btb_idx()     - BTB index of a PC for a given depth
//            btb_tag()     - BTB tag of a PC for a given depth
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package fetch_pkg;

  // Widest address the BTB entry type can carry; designs use XLEN <= this.
  localparam int MAX_XLEN = 64;

  localparam logic [1:0] CTR_WEAK_NT = 2'b01;
  localparam logic [1:0] CTR_WEAK_T  = 2'b10;

  // Tag and target are held zero-extended to MAX_XLEN so one type serves
  // every XLEN/BTB_ENTRIES combination.
  typedef struct packed {
    logic                valid;
    logic [MAX_XLEN-1:0] tag;
    logic [MAX_XLEN-1:0] target;
    logic [1:0]          ctr;
  } btb_entry_t;

  // Index = pc[IDX+1:2] with IDX = log2(entries).
  function automatic int unsigned btb_idx(input logic [MAX_XLEN-1:0] pc,
                                          input int unsigned         entries);
    int unsigned         idx_bits;
    logic [MAX_XLEN-1:0] mask;
    idx_bits = $clog2(entries);
    mask     = (MAX_XLEN'(1) << idx_bits) - MAX_XLEN'(1);
    return 32'((pc >> 2) & mask);
  endfunction

  // Tag = pc[XLEN-1:IDX+2], zero-extended.
  function automatic logic [MAX_XLEN-1:0] btb_tag(input logic [MAX_XLEN-1:0] pc,
                                                  input int unsigned         entries);
    int unsigned idx_bits;
    idx_bits = $clog2(entries);
    return pc >> (idx_bits + 2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_pc_gen_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : fetch_pc_gen_if
// Purpose  : Bundle of all non-clock signals of fetch_pc_gen.
// Modports : master - drives redirect/flush/update/out_ready, receives out_*
//            slave  - the PC generator itself
// Signals  : redirect_valid/redirect_pc, fence_flush,
//            upd_valid/upd_pc/upd_target/upd_taken, out_ready,
//            out_valid/out_pc/out_pred_taken/out_pred_target
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
interface fetch_pc_gen_if #(
  parameter int XLEN = 64
);
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            fence_flush;
  logic            upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic [XLEN-1:0] upd_target;
  logic            upd_taken;
  logic            out_ready;
  logic            out_valid;
  logic [XLEN-1:0] out_pc;
  logic            out_pred_taken;
  logic [XLEN-1:0] out_pred_target;

  modport master (
    output redirect_valid, redirect_pc, fence_flush,
    output upd_valid, upd_pc, upd_target, upd_taken, out_ready,
    input  out_valid, out_pc, out_pred_taken, out_pred_target
  );

  modport slave (
    input  redirect_valid, redirect_pc, fence_flush,
    input  upd_valid, upd_pc, upd_target, upd_taken, out_ready,
    output out_valid, out_pc, out_pred_taken, out_pred_target
  );
endinterface
`default_nettype wire

// File: rtl/btb_2bit.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : btb_2bit
// Purpose  : Direct-mapped branch target buffer with 2-bit saturating
//            counters. Combinational lookup, registered update and flush.
// Ports    : clk, rst           - clock, asynchronous active-high reset
//            i_lookup_pc        - PC being fetched
//            o_pred_taken       - hit and counter predicts taken
//            o_pred_target      - stored target of the indexed entry
//            i_flush            - invalidate every entry (wins over update)
//            i_upd_valid/pc/target/taken - resolved branch training
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module btb_2bit
  import fetch_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int BTB_ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] i_lookup_pc,
  output logic            o_pred_taken,
  output logic [XLEN-1:0] o_pred_target,
  input  logic            i_flush,
  input  logic            i_upd_valid,
  input  logic [XLEN-1:0] i_upd_pc,
  input  logic [XLEN-1:0] i_upd_target,
  input  logic            i_upd_taken
);

  localparam int IDX = $clog2(BTB_ENTRIES);

  localparam btb_entry_t c_empty_entry = '{
    valid:  1'b0,
    tag:    '0,
    target: '0,
    ctr:    CTR_WEAK_NT
  };

  btb_entry_t r_btb [BTB_ENTRIES];

  logic [IDX-1:0]      w_l_idx;
  logic [MAX_XLEN-1:0] w_l_tag;
  logic [IDX-1:0]      w_u_idx;
  logic [MAX_XLEN-1:0] w_u_tag;
  logic                w_u_hit;
  logic [1:0]          w_u_ctr;
  logic [1:0]          w_u_ctr_next;

  // Lookup reads the registered array, so a same-cycle update at the same
  // index is only seen from the following cycle.
  always_comb begin
    w_l_idx       = IDX'(btb_idx(MAX_XLEN'(i_lookup_pc), BTB_ENTRIES));
    w_l_tag       = btb_tag(MAX_XLEN'(i_lookup_pc), BTB_ENTRIES);
    o_pred_taken  = r_btb[w_l_idx].valid && (r_btb[w_l_idx].tag == w_l_tag)
                    && r_btb[w_l_idx].ctr[1];
    o_pred_target = r_btb[w_l_idx].target[XLEN-1:0];
  end

  always_comb begin
    w_u_idx = IDX'(btb_idx(MAX_XLEN'(i_upd_pc), BTB_ENTRIES));
    w_u_tag = btb_tag(MAX_XLEN'(i_upd_pc), BTB_ENTRIES);
    w_u_hit = r_btb[w_u_idx].valid && (r_btb[w_u_idx].tag == w_u_tag);
    w_u_ctr = r_btb[w_u_idx].ctr;
    if (i_upd_taken) begin
      w_u_ctr_next = (w_u_ctr == 2'b11) ? w_u_ctr : w_u_ctr + 2'd1;
    end else begin
      w_u_ctr_next = (w_u_ctr == 2'b00) ? w_u_ctr : w_u_ctr - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        r_btb[i] <= c_empty_entry;
      end
    end else if (i_flush) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        r_btb[i] <= c_empty_entry;
      end
    end else if (i_upd_valid) begin
      if (w_u_hit) begin
        r_btb[w_u_idx].ctr <= w_u_ctr_next;
        if (i_upd_taken) begin
          r_btb[w_u_idx].target <= MAX_XLEN'(i_upd_target);
        end
      end else if (i_upd_taken) begin
        // Miss on a taken branch evicts whatever lived at this index.
        r_btb[w_u_idx] <= '{
          valid:  1'b1,
          tag:    w_u_tag,
          target: MAX_XLEN'(i_upd_target),
          ctr:    CTR_WEAK_T
        };
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_pc_gen.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : fetch_pc_gen
// Purpose  : First-stage fetch address generator. Holds the fetch PC, offers
//            it downstream through valid/ready, and picks the next PC from
//            redirect > BTB prediction (when accepted) > hold.
// Ports    : clk  - clock
//            rst  - asynchronous active-high reset
//            bus  - fetch_pc_gen_if.slave (redirect, flush, update,
//                   out_ready in; out_valid/out_pc/out_pred_* out)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter int              XLEN        = 64,
  parameter int              BTB_ENTRIES = 16,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  fetch_pc_gen_if.slave        bus
);

  logic [XLEN-1:0] r_pc;
  logic            r_valid;

  logic            w_btb_taken;
  logic [XLEN-1:0] w_btb_target;
  logic [XLEN-1:0] w_pred_target;

  btb_2bit #(
    .XLEN        (XLEN),
    .BTB_ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk           (clk),
    .rst           (rst),
    .i_lookup_pc   (r_pc),
    .o_pred_taken  (w_btb_taken),
    .o_pred_target (w_btb_target),
    .i_flush       (bus.fence_flush),
    .i_upd_valid   (bus.upd_valid),
    .i_upd_pc      (bus.upd_pc),
    .i_upd_target  (bus.upd_target),
    .i_upd_taken   (bus.upd_taken)
  );

  // Fall-through wraps modulo 2^XLEN.
  assign w_pred_target = w_btb_taken ? w_btb_target : (r_pc + XLEN'(4));

  // Outputs are functions of registered state only.
  assign bus.out_valid       = r_valid;
  assign bus.out_pc          = r_pc;
  assign bus.out_pred_taken  = w_btb_taken;
  assign bus.out_pred_target = w_pred_target;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_valid <= 1'b0;
    end else if (!r_valid) begin
      // First edge out of reset only raises valid; RESET_PC is fetched first.
      r_valid <= 1'b1;
    end else if (bus.redirect_valid) begin
      // Redirect overrides backpressure; the low two bits are forced to zero.
      r_pc <= bus.redirect_pc & ~XLEN'(3);
    end else if (bus.out_ready) begin
      r_pc <= w_pred_target;
    end
  end

endmodule
`default_nettype wire
